i2c_slave: RTL
==============

# i2c_slave

I2C target (slave) that responds to the `i2c_master` at the far end of the same bus. It decodes START, STOP and repeated-START, matches a fixed 7-bit address, and accepts an 8-bit sub-address. Written bytes go to a simple register port; read bytes are fetched from that port and returned to the master. It sits beside the SoC's register space so an I2C master can exercise peripherals, and it serves as the bus model in `i2c_master` simulations. No clock stretching; SCL is input-only.

## Interface

- `SLAVE_ADDR`, default 7'h50: 7-bit bus address this target answers to.
- `i_clk` in 1: system clock; all logic is synchronous to it.
- `reset_n` in 1: asynchronous, active-low reset.
- `scl_i` in 1: SCL line sample, asynchronous to `i_clk`.
- `sda_i` in 1: SDA line sample, asynchronous to `i_clk`.
- `sda_oe` out 1: 1 = pull SDA low (open-drain); 0 = release.
- `reg_addr` out 8: current register address (sub-address pointer).
- `wr_data` out 8: received data byte, valid while `wr_en` = 1.
- `wr_en` out 1: one-cycle write strobe.
- `rd_en` out 1: one-cycle read request for `reg_addr`.
- `rd_data` in 8: read data, valid exactly 1 `i_clk` after `rd_en`.
- `busy` out 1: 1 from an addressed START until the following STOP.

## Operation

- Synchronization:
  - `scl_i` and `sda_i` each pass through 2 flip-flops.
  - Both synchronizers reset to 1, the idle bus level.
  - SCL rise and fall are single-cycle pulses derived from the synchronized value and a 1-cycle delayed copy.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- START has priority in every state, including repeated START. It enters ADDR, clears the bit counter and releases `sda_oe`.
- STOP in any state enters IDLE, releases `sda_oe` and clears `busy`.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first, one bit per SCL rise.
    - `[7:1]` == SLAVE_ADDR: go to ADDR_ACK.
    - Otherwise: go to IGNORE.
  - ADDR_ACK: assert `sda_oe` on the SCL fall after bit 8; release it on the next SCL fall. `busy` = 1.
    - R/W = 0: go to SUB.
    - R/W = 1: go to RDATA.
  - SUB: shift 8 bits, then `reg_addr` <= byte. Go to SUB_ACK, which ACKs like ADDR_ACK, then go to WDATA.
  - WDATA: shift 8 bits.
    - On the 8th SCL rise, pulse `wr_en` for 1 cycle with `wr_data` = byte and the current `reg_addr`.
    - Go to WDATA_ACK, which ACKs and then returns to WDATA.
    - `reg_addr` increments on the cycle after `wr_en`.
  - RDATA:
    - On entry, pulse `rd_en`; load the shift register from `rd_data` on the next cycle.
    - Drive bit 7 at the SCL fall that ends the ACK, and each following bit on each SCL fall. A bit value of 0 sets `sda_oe` = 1.
    - After 8 bits, release SDA at the next SCL fall and go to RACK.
  - RACK: sample SDA on the SCL rise.
    - 0 (master ACK): increment `reg_addr`, then go to RDATA (next `rd_en`).
    - 1 (NACK): go to IGNORE.
  - IGNORE: `sda_oe` = 0; wait for START or STOP.
- `reg_addr` keeps its value across transactions. A write of only the sub-address followed by a repeated START and a read gives a combined-format read.
- `reg_addr` increments modulo 256: 8'hFF → 8'h00.

## Timing

- Reset values: `sda_oe` = 0, `reg_addr` = 8'h00, `wr_data` = 8'h00, `wr_en` = 0, `rd_en` = 0, `busy` = 0, state = IDLE.
- Reset is asynchronous. Asserting it mid-transfer releases SDA immediately.
- Line-to-action latency is 3 `i_clk` cycles: 2 synchronizer cycles plus 1 edge-detect cycle.
- Requirement: `i_clk` ≥ 10× the SCL frequency.
- Requirement: SDA changes from the master come ≥ 4 `i_clk` after an SCL fall.
- `wr_en` and `rd_en` are never high in the same cycle. Each is exactly 1 cycle wide.
- STOP or START mid-byte discards the partial byte: no `wr_en` and no `reg_addr` change.

## Test plan

- Write, SLAVE_ADDR = 7'h50:
  - Stimulus: START, 0xA0, 0x10, 0x5A, 0x3C, STOP.
  - Response: SDA is low on all four 9th clocks; `wr_en` pulses with (0x10, 0x5A) then (0x11, 0x3C); `reg_addr` ends at 0x12; `busy` falls at STOP.
- Combined read:
  - Stimulus: START, 0xA0, 0x20, repeated START, 0xA1; master ACKs byte 1 and NACKs byte 2; STOP. Bench model: `rd_data` = ~`reg_addr`.
  - Response: master reads 0xDF then 0xDE; `rd_en` pulses at `reg_addr` 0x20 and 0x21; SDA is released after the NACK.
- Address mismatch:
  - Stimulus: START, 0xA2, 0x10, 0x55, STOP.
  - Response: `sda_oe` stays 0 throughout; no `wr_en`; `busy` stays 0.
- Wrap:
  - Stimulus: sub-address 0xFF, then data 0x01, 0x02.
  - Response: writes go to 0xFF then 0x00; `reg_addr` ends at 0x01.
- Abort:
  - Stimulus: STOP after 4 data bits; separately, `reset_n` = 0 during the ACK of a data byte.
  - Response: no `wr_en`, and `sda_oe` = 0 within 1 cycle of reset. A following full write completes correctly.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target with fixed 7-bit address, 8-bit sub-address pointer and a simple
// register-port back end; no clock stretching, SCL is input-only.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i_clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  state_t r_state, w_next;

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_phase, r_rw, r_sda_oe, r_wr_en, r_rd_en, r_rd_pend, r_busy;
  logic [7:0] r_reg_addr, r_wr_data;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_byte_done, w_ack_state, w_shift_state, w_enter;
  logic [7:0] w_byte;

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;    r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda_i;    r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise    = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall    = ~r_scl_s2 & r_scl_d;
  assign w_start       = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop        = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte        = {r_shift[6:0], r_sda_s2};
  assign w_byte_done   = w_scl_rise & (r_bitcnt == 3'd7);
  assign w_ack_state   = (r_state == S_ADDR_ACK) || (r_state == S_SUB_ACK) ||
                         (r_state == S_WDATA_ACK);
  assign w_shift_state = (r_state == S_ADDR) || (r_state == S_SUB) || (r_state == S_WDATA);
  assign w_enter       = (w_next != r_state);

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // RACK samples the master's ACK on the rise but waits for the fall before
  // re-entering RDATA, so every RDATA entry lands while SCL is low.
  always_comb begin
    w_next = r_state;
    if (w_start)     w_next = S_ADDR;
    else if (w_stop) w_next = S_IDLE;
    else begin
      case (r_state)
        S_ADDR:      if (w_byte_done) w_next = (w_byte[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  if (w_scl_fall && r_phase) w_next = r_rw ? S_RDATA : S_SUB;
        S_SUB:       if (w_byte_done) w_next = S_SUB_ACK;
        S_SUB_ACK:   if (w_scl_fall && r_phase) w_next = S_WDATA;
        S_WDATA:     if (w_byte_done) w_next = S_WDATA_ACK;
        S_WDATA_ACK: if (w_scl_fall && r_phase) w_next = S_WDATA;
        S_RDATA:     if (w_scl_fall && (r_bitcnt == 3'd7)) w_next = S_RACK;
        S_RACK: begin
          if (w_scl_rise && !r_phase && r_sda_s2) w_next = S_IGNORE;
          else if (w_scl_fall && r_phase)         w_next = S_RDATA;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_phase    <= 1'b0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_reg_addr <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rd_en   <= (w_next == S_RDATA) && (r_state != S_RDATA);
      r_rd_pend <= r_rd_en;
      r_wr_en   <= (r_state == S_WDATA) && (w_next == S_WDATA_ACK);

      if (r_state == S_ADDR && w_byte_done) r_rw <= r_sda_s2;

      if (r_state == S_WDATA && w_next == S_WDATA_ACK) r_wr_data <= w_byte;

      if (r_state == S_SUB && w_next == S_SUB_ACK)
        r_reg_addr <= w_byte;
      else if (r_wr_en || (r_state == S_RACK && w_scl_rise && !r_phase && !r_sda_s2))
        r_reg_addr <= r_reg_addr + 8'd1;

      if (r_rd_pend)
        r_shift <= rd_data;
      else if (w_scl_rise && w_shift_state)
        r_shift <= w_byte;
      else if (w_scl_fall && r_state == S_RDATA)
        r_shift <= {r_shift[6:0], 1'b0};

      if (w_start || w_enter)
        r_bitcnt <= '0;
      else if ((w_scl_rise && w_shift_state) || (w_scl_fall && r_state == S_RDATA))
        r_bitcnt <= r_bitcnt + 3'd1;

      if (w_start || w_enter)
        r_phase <= 1'b0;
      else if ((w_scl_fall && w_ack_state) || (w_scl_rise && r_state == S_RACK))
        r_phase <= 1'b1;

      if (w_start || w_stop)
        r_sda_oe <= 1'b0;
      else if (w_ack_state) begin
        if (w_scl_fall) r_sda_oe <= ~r_phase;
      end else if (r_state == S_RDATA) begin
        if (r_rd_pend)       r_sda_oe <= ~rd_data[7];
        else if (w_scl_fall) r_sda_oe <= (r_bitcnt == 3'd7) ? 1'b0 : ~r_shift[6];
      end else
        r_sda_oe <= 1'b0;

      if (w_stop) r_busy <= 1'b0;
      else if (r_state == S_ADDR && w_next == S_ADDR_ACK) r_busy <= 1'b1;
    end
  end

  assign sda_oe   = r_sda_oe;
  assign reg_addr = r_reg_addr;
  assign wr_data  = r_wr_data;
  assign wr_en    = r_wr_en;
  assign rd_en    = r_rd_en;
  assign busy     = r_busy;

endmodule
